sort_controller: RTL and testbench
==================================

Name: sort_controller

Overview:
- FSM sequencer for the 8-entry signed selection-sort datapath: counters, address/write-data muxes, memory, A/B registers and signed comparator.
- Runs three phases in order:
  - loads `size` words from an input handshake into memory;
  - runs an in-place selection sort using compare-and-swap;
  - streams the sorted words out under valid/ready.
- Sits between the top-level host interface and the datapath. The controller drives every datapath control line and is the only block that does.

Parameters:
- size, 8, number of 32-bit entries sorted. Power of 2, ≥2.
- Derived: AW = $clog2(size); all counter/address values are AW+1 bits.

Ports:
- clk  in  1  clock; all state changes on rising edge
- rstn  in  1  reset, synchronous, active-high (1 = reset), sampled on rising clk
- start  in  1  begin a new run; accepted only in IDLE
- in_valid  in  1  data_in holds a valid word
- in_ready  out  1  controller accepts a word this cycle
- out_ready  in  1  consumer accepts sorted word
- out_valid  out  1  datapath `sorted` holds a valid word
- busy  out  1  high from the start acceptance through the final output transfer
- cnt, cnt_i, cnt_j  in  AW+1 each  datapath counter values
- result_cmp  in  1  signed(reg_a) > signed(reg_b)
- ena_cnt, ena_cnti, ena_cntj  out  1 each  counter increment enables
- load_cnt, load_cnti, load_cntj  out  1 each  counter loads (cnt/cnt_i←0, cnt_j←cnt_i+1)
- s0, s1, s2, s3  out  1 each  mux selects (s0: i/j, s1: cnt/ij, s2: a/b, s3: data_in/reg)
- we, re  out  1 each  memory write/read strobes
- en_rega, en_regb  out  1 each  A/B register load enables
- done  out  1  gates `sorted` onto the datapath output

Behaviour:
- Reset:
  - State ← IDLE.
  - All outputs 0, except load_cnt, load_cnti and load_cntj, which are 1 during reset so the counters clear.
  - rstn mid-run aborts immediately. Memory contents are don't-care after an abort.
- Memory timing: write on the edge where we=1. Read data is valid the cycle after re=1 at a stable address.
- IDLE:
  - load_cnt=1.
  - start=1 → LOAD.
- LOAD:
  - in_ready=1, s1=0, s3=0.
  - When in_valid=1: we=1 and ena_cnt=1.
  - If in_valid=1 and cnt==size-1 → S_INIT.
  - in_valid=0 → stay in LOAD with no writes.
- S_INIT: load_cnti=1, load_cnt=1 → J_INIT.
- J_INIT: load_cntj=1 → RD_A.
- RD_A: s1=1, s0=0, re=1 → LD_A.
- LD_A: s1=1, s0=0, re=1, en_rega=1 → RD_B.
- RD_B: s1=1, s0=1, re=1 → LD_B.
- LD_B: s1=1, s0=1, re=1, en_regb=1 → CMP.
- CMP: result_cmp=1 → WR_I; otherwise → NEXT_J.
- WR_I: s1=1, s0=0, s3=1, s2=1, we=1 (mem[i] ← reg_b) → WR_J.
- WR_J: s1=1, s0=1, s3=1, s2=0, we=1 (mem[j] ← reg_a) → NEXT_J.
- NEXT_J:
  - cnt_j==size-1 → NEXT_I.
  - Otherwise ena_cntj=1 → RD_A. A is re-read because it may have been swapped.
- NEXT_I:
  - cnt_i==size-2 → O_RD.
  - Otherwise ena_cnti=1 → J_INIT.
- O_RD: s1=0, re=1, done=1 → O_VLD.
- O_VLD:
  - s1=0, re=1, done=1, out_valid=1.
  - out_ready=0 → hold state; address and data stay stable.
  - out_ready=1 and cnt==size-1 → IDLE.
  - out_ready=1 otherwise: ena_cnt=1 → O_RD.
- busy: 1 in every state except IDLE.
- Equal values: result_cmp=0, so no swap and ordering is stable for duplicates.
- Counter wrap: never reached. Termination is decided on compares against size-1 and size-2, never on overflow.
- start outside IDLE: ignored.
- in_valid outside LOAD: ignored; in_ready=0.
- Cycle cost of one compare: 6 cycles without swap, 8 with swap.

Optional Feature:
- Macro: SORT_DESCEND_EN.
- Defined: the CMP branch inverts. result_cmp=0 → WR_I; result_cmp=1 → NEXT_J. Output is descending. Equal pairs are swapped, which is harmless.
- Undefined: ascending order exactly as specified above.

Test Plan:
- Reset mid-sort (rstn=1 for one cycle in CMP) → next cycle: IDLE, busy=0, we=0, re=0, load_cnt=load_cnti=load_cntj=1 during reset.
- Load 8,7,6,5,4,3,2,1 with continuous in_valid → in_ready high for 8 cycles, exactly 8 writes at addresses 0..7. Output with out_ready=1 → 1,2,3,4,5,6,7,8.
- Signed mix -5,3,0,-32768,7,7,-1,2 → output -32768,-5,-1,0,2,3,7,7. No swap is issued for the equal 7s (we=0 in CMP→NEXT_J).
- Already sorted 0..7 → zero cycles with s3=1 and we=1. Sort phase lasts 28×6 cycles + init overhead.
- in_valid gaps (valid every 3rd cycle) and out_ready toggling 1,0,0,1 → no lost or duplicated words. out_valid and sorted hold stable while out_ready=0.
- SORT_DESCEND_EN defined, input 1..8 → output 8,7,6,5,4,3,2,1. start pulse during O_VLD is ignored and busy drops after the 8th transfer.

Source files
------------

// File: rtl/sort_controller.sv
// Sequencer for the 8-entry signed selection-sort datapath: load, in-place compare-and-swap sort, stream out.
// Define SORT_DESCEND_EN to invert the compare branch and produce descending output.
module sort_controller #(
    parameter int size = 8
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    start,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    out_ready,
    output logic                    out_valid,
    output logic                    busy,
    input  logic [$clog2(size):0]   cnt,
    input  logic [$clog2(size):0]   cnt_i,
    input  logic [$clog2(size):0]   cnt_j,
    input  logic                    result_cmp,
    output logic                    ena_cnt,
    output logic                    ena_cnti,
    output logic                    ena_cntj,
    output logic                    load_cnt,
    output logic                    load_cnti,
    output logic                    load_cntj,
    output logic                    s0,
    output logic                    s1,
    output logic                    s2,
    output logic                    s3,
    output logic                    we,
    output logic                    re,
    output logic                    en_rega,
    output logic                    en_regb,
    output logic                    done
);

    localparam int AW = $clog2(size);
    localparam logic [AW:0] LAST_IDX = (AW+1)'(size - 1);
    localparam logic [AW:0] PENULT_IDX = (AW+1)'(size - 2);

    typedef enum logic [3:0] {
        IDLE, LOAD, S_INIT, J_INIT, RD_A, LD_A, RD_B, LD_B,
        CMP, WR_I, WR_J, NEXT_J, NEXT_I, O_RD, O_VLD
    } state_e;

    state_e state_q, state_d;

    always_ff @(posedge clk) begin
        if (rstn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = (state_q != IDLE);
        ena_cnt   = 1'b0;
        ena_cnti  = 1'b0;
        ena_cntj  = 1'b0;
        load_cnt  = 1'b0;
        load_cnti = 1'b0;
        load_cntj = 1'b0;
        s0        = 1'b0;
        s1        = 1'b0;
        s2        = 1'b0;
        s3        = 1'b0;
        we        = 1'b0;
        re        = 1'b0;
        en_rega   = 1'b0;
        en_regb   = 1'b0;
        done      = 1'b0;

        case (state_q)
            IDLE: begin
                load_cnt = 1'b1;
                if (start) state_d = LOAD;
            end
            LOAD: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    we      = 1'b1;
                    ena_cnt = 1'b1;
                    if (cnt == LAST_IDX) state_d = S_INIT;
                end
            end
            S_INIT: begin
                load_cnti = 1'b1;
                load_cnt  = 1'b1;
                state_d   = J_INIT;
            end
            J_INIT: begin
                load_cntj = 1'b1;
                state_d   = RD_A;
            end
            RD_A: begin
                s1      = 1'b1;
                re      = 1'b1;
                state_d = LD_A;
            end
            LD_A: begin
                s1      = 1'b1;
                re      = 1'b1;
                en_rega = 1'b1;
                state_d = RD_B;
            end
            RD_B: begin
                s1      = 1'b1;
                s0      = 1'b1;
                re      = 1'b1;
                state_d = LD_B;
            end
            LD_B: begin
                s1      = 1'b1;
                s0      = 1'b1;
                re      = 1'b1;
                en_regb = 1'b1;
                state_d = CMP;
            end
            CMP: begin
`ifdef SORT_DESCEND_EN
                state_d = result_cmp ? NEXT_J : WR_I;
`else
                state_d = result_cmp ? WR_I : NEXT_J;
`endif
            end
            // swap: mem[i] <- reg_b, then mem[j] <- reg_a
            WR_I: begin
                s1      = 1'b1;
                s3      = 1'b1;
                s2      = 1'b1;
                we      = 1'b1;
                state_d = WR_J;
            end
            WR_J: begin
                s1      = 1'b1;
                s0      = 1'b1;
                s3      = 1'b1;
                we      = 1'b1;
                state_d = NEXT_J;
            end
            NEXT_J: begin
                if (cnt_j == LAST_IDX) begin
                    state_d = NEXT_I;
                end else begin
                    ena_cntj = 1'b1;
                    state_d  = RD_A;
                end
            end
            NEXT_I: begin
                if (cnt_i == PENULT_IDX) begin
                    state_d = O_RD;
                end else begin
                    ena_cnti = 1'b1;
                    state_d  = J_INIT;
                end
            end
            O_RD: begin
                re      = 1'b1;
                done    = 1'b1;
                state_d = O_VLD;
            end
            O_VLD: begin
                re        = 1'b1;
                done      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    if (cnt == LAST_IDX) begin
                        state_d = IDLE;
                    end else begin
                        ena_cnt = 1'b1;
                        state_d = O_RD;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Reset silences every strobe but holds the counter loads so the datapath clears.
        if (rstn) begin
            in_ready  = 1'b0;
            out_valid = 1'b0;
            busy      = 1'b0;
            ena_cnt   = 1'b0;
            ena_cnti  = 1'b0;
            ena_cntj  = 1'b0;
            load_cnt  = 1'b1;
            load_cnti = 1'b1;
            load_cntj = 1'b1;
            s0        = 1'b0;
            s1        = 1'b0;
            s2        = 1'b0;
            s3        = 1'b0;
            we        = 1'b0;
            re        = 1'b0;
            en_rega   = 1'b0;
            en_regb   = 1'b0;
            done      = 1'b0;
            state_d   = IDLE;
        end
    end

endmodule

// File: tb/tb_sort_controller.sv
// Directed bench for sort_controller with a behavioural selection-sort datapath around it.
module tb_sort_controller;
    localparam int SIZE = 8;
    localparam int AW = $clog2(SIZE);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rstn, start, in_valid, in_ready, out_ready, out_valid, busy;
    logic [AW:0] cnt, cnt_i, cnt_j;
    logic result_cmp;
    logic ena_cnt, ena_cnti, ena_cntj, load_cnt, load_cnti, load_cntj;
    logic s0, s1, s2, s3, we, re, en_rega, en_regb, done;

    sort_controller #(.size(SIZE)) dut (
        .clk(clk), .rstn(rstn), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .out_ready(out_ready), .out_valid(out_valid), .busy(busy),
        .cnt(cnt), .cnt_i(cnt_i), .cnt_j(cnt_j), .result_cmp(result_cmp),
        .ena_cnt(ena_cnt), .ena_cnti(ena_cnti), .ena_cntj(ena_cntj),
        .load_cnt(load_cnt), .load_cnti(load_cnti), .load_cntj(load_cntj),
        .s0(s0), .s1(s1), .s2(s2), .s3(s3), .we(we), .re(re),
        .en_rega(en_rega), .en_regb(en_regb), .done(done)
    );

    // Datapath model: counters, address/write muxes, sync-read memory, A/B registers, comparator.
    logic signed [31:0] mem [SIZE];
    logic signed [31:0] rd_q, reg_a, reg_b, data_in, wdata, sorted;
    logic [AW-1:0] addr;

    always_comb begin
        addr  = s1 ? (s0 ? cnt_j[AW-1:0] : cnt_i[AW-1:0]) : cnt[AW-1:0];
        wdata = s3 ? (s2 ? reg_b : reg_a) : data_in;
    end
    assign result_cmp = (reg_a > reg_b);
    assign sorted = done ? rd_q : 32'sd0;

    always @(posedge clk) begin
        if (load_cnt) cnt <= '0; else if (ena_cnt) cnt <= cnt + 1'b1;
        if (load_cnti) cnt_i <= '0; else if (ena_cnti) cnt_i <= cnt_i + 1'b1;
        if (load_cntj) cnt_j <= cnt_i + 1'b1; else if (ena_cntj) cnt_j <= cnt_j + 1'b1;
        if (we) mem[addr] <= wdata;
        if (re) rd_q <= mem[addr];
        if (en_rega) reg_a <= rd_q;
        if (en_regb) reg_b <= rd_q;
    end

    // Activity monitor: load writes, swap writes, in_ready cycles, load addresses.
    logic mon_clr;
    int n_wr, n_swap, n_rdy;
    int la [SIZE];
    always @(posedge clk) begin
        if (mon_clr) begin
            n_wr <= 0;
            n_swap <= 0;
            n_rdy <= 0;
        end else begin
            if (we && !s3) begin
                n_wr <= n_wr + 1;
                if (n_wr < SIZE) la[n_wr] <= int'(addr);
            end
            if (we && s3) n_swap <= n_swap + 1;
            if (in_ready) n_rdy <= n_rdy + 1;
        end
    end

    int n_assert = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic begin_run(input string tag);
        mon_clr = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        mon_clr = 1'b0;
        #1;
        chk({tag, "_busy_load"}, busy, 1);
        chk({tag, "_in_ready"}, in_ready, 1);
    endtask

    task automatic load_words(input logic signed [31:0] vin [SIZE], input int gap);
        for (int k = 0; k < SIZE; k++) begin
            in_valid = 1'b1;
            data_in = vin[k];
            step();
            in_valid = 1'b0;
            for (int g = 0; g < gap; g++) step();
        end
    endtask

    task automatic wait_sorted(input string tag, output int cyc);
        cyc = 0;
        while (!out_valid && cyc < 5000) begin
            step();
            cyc++;
        end
        chk({tag, "_reach_out"}, out_valid, 1);
    endtask

    task automatic drain(input string tag, input logic signed [31:0] vexp [SIZE],
                         input bit toggle, input bit poke_start);
        logic pat [4];
        logic signed [31:0] held;
        bit hold;
        int got;
        int cyc;
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        hold = 1'b0;
        got = 0;
        cyc = 0;
        held = 0;
        while (got < SIZE && cyc < 500) begin
            out_ready = toggle ? pat[cyc % 4] : 1'b1;
            start = poke_start && (cyc == 1);
            #1;
            if (hold) begin
                chk($sformatf("%s_hold_valid%0d", tag, cyc), out_valid, 1);
                chk($sformatf("%s_hold_data%0d", tag, cyc), sorted, held);
            end
            hold = 1'b0;
            if (out_valid && out_ready) begin
                chk($sformatf("%s_out%0d", tag, got), sorted, vexp[got]);
                got++;
            end else if (out_valid) begin
                hold = 1'b1;
                held = sorted;
            end
            step();
            cyc++;
        end
        out_ready = 1'b0;
        start = 1'b0;
        #1;
        chk({tag, "_count"}, got, SIZE);
        chk({tag, "_busy_end"}, busy, 0);
        chk({tag, "_valid_end"}, out_valid, 0);
        step();
        chk({tag, "_busy_after"}, busy, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic signed [31:0] v_dn [SIZE], v_mix [SIZE], v_up0 [SIZE], v_up1 [SIZE];
        logic signed [31:0] e_dn [SIZE], e_mix [SIZE], e_up0 [SIZE], e_up1 [SIZE];
        int sc;
        int k;

        v_dn  = '{8, 7, 6, 5, 4, 3, 2, 1};
        v_mix = '{-5, 3, 0, -32768, 7, 7, -1, 2};
        v_up0 = '{0, 1, 2, 3, 4, 5, 6, 7};
        v_up1 = '{1, 2, 3, 4, 5, 6, 7, 8};
`ifdef SORT_DESCEND_EN
        e_dn  = '{8, 7, 6, 5, 4, 3, 2, 1};
        e_mix = '{7, 7, 3, 2, 0, -1, -5, -32768};
        e_up0 = '{7, 6, 5, 4, 3, 2, 1, 0};
        e_up1 = '{8, 7, 6, 5, 4, 3, 2, 1};
`else
        e_dn  = '{1, 2, 3, 4, 5, 6, 7, 8};
        e_mix = '{-32768, -5, -1, 0, 2, 3, 7, 7};
        e_up0 = '{0, 1, 2, 3, 4, 5, 6, 7};
        e_up1 = '{1, 2, 3, 4, 5, 6, 7, 8};
`endif

        rstn = 1'b1; start = 1'b0; in_valid = 1'b0; data_in = 0; out_ready = 1'b0; mon_clr = 1'b1;
        step();
        chk("rst_load_cnt", load_cnt, 1);
        chk("rst_load_cnti", load_cnti, 1);
        chk("rst_load_cntj", load_cntj, 1);
        chk("rst_busy", busy, 0);
        chk("rst_we", we, 0);
        chk("rst_re", re, 0);
        chk("rst_in_ready", in_ready, 0);
        step();
        rstn = 1'b0;
        #1;
        chk("idle_busy", busy, 0);
        chk("idle_load_cnt", load_cnt, 1);
        chk("idle_in_ready", in_ready, 0);
        step();

        // Reverse-ordered load with continuous valid.
        begin_run("dn");
        load_words(v_dn, 0);
        chk("dn_writes", n_wr, SIZE);
        chk("dn_rdy_cycles", n_rdy, SIZE);
        for (int a = 0; a < SIZE; a++) chk($sformatf("dn_addr%0d", a), la[a], a);
        wait_sorted("dn", sc);
        drain("dn", e_dn, 1'b0, 1'b0);

        // Signed values with a duplicate pair.
        begin_run("mix");
        load_words(v_mix, 0);
        wait_sorted("mix", sc);
        drain("mix", e_mix, 1'b0, 1'b0);

        // Already sorted input: no swap writes, 6-cycle compares only.
        begin_run("srt");
        load_words(v_up0, 0);
        wait_sorted("srt", sc);
`ifndef SORT_DESCEND_EN
        chk("srt_swaps", n_swap, 0);
        chk("srt_sort_cycles", sc, 184);
`endif
        drain("srt", e_up0, 1'b0, 1'b0);

        // Sparse input valid, toggling output ready, start pulse during output.
        begin_run("gap");
        load_words(v_up1, 2);
        chk("gap_writes", n_wr, SIZE);
        wait_sorted("gap", sc);
        drain("gap", e_up1, 1'b1, 1'b1);

        // Abort while in CMP.
        begin_run("abt");
        load_words(v_dn, 0);
        k = 0;
        while (!en_regb && k < 100) begin
            step();
            k++;
        end
        chk("abt_reach_ldb", en_regb, 1);
        step();
        rstn = 1'b1;
        #1;
        chk("abt_load_cnt", load_cnt, 1);
        chk("abt_load_cnti", load_cnti, 1);
        chk("abt_load_cntj", load_cntj, 1);
        chk("abt_we", we, 0);
        chk("abt_busy_rst", busy, 0);
        step();
        rstn = 1'b0;
        #1;
        chk("abt_idle_busy", busy, 0);
        chk("abt_idle_we", we, 0);
        chk("abt_idle_re", re, 0);
        chk("abt_idle_load_cnt", load_cnt, 1);
        step();

        // Recovery run after the abort.
        begin_run("rec");
        load_words(v_mix, 0);
        wait_sorted("rec", sc);
        drain("rec", e_mix, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
